// File: rtl/cache_fill_fsm.sv
// Cache line fill sequencer: optional 8-word victim write-back, then 8-word line fill, then tag update.
// Latency: 9 busy cycles for a clean miss, 17 for a dirty miss (counted from the accepting edge).
// Backpressure: none; memory serves one word per cycle, and miss_detected is ignored while busy.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  evict_dirty,
    input  logic [ADDR_WIDTH-1:0] evict_address,
    input  logic [15:0]           evict_data,
    input  logic [15:0]           mem_data_in,
    output logic                  fsm_busy,
    output logic [2:0]            wb_word,
    output logic                  write_data_array,
    output logic [2:0]            fill_word,
    output logic [15:0]           fill_data,
    output logic                  write_tag_array,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [15:0]           mem_data_out,
    output logic                  mem_enable,
    output logic                  mem_wr
);

    // Line number = address with the 4 byte-offset bits stripped.
    localparam int LINE_BITS = ADDR_WIDTH - 4;
    // Terminal value of the word counter (last word of the line).
    localparam logic [2:0] LAST_WORD = 3'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    // One memory request per cycle; enable/wr travel together with address and data.
    typedef struct packed {
        logic                  enable;
        logic                  wr;
        logic [ADDR_WIDTH-1:0] address;
        logic [15:0]           data;
    } mem_req_t;

    // Cache-side strobes and indices.
    typedef struct packed {
        logic        busy;
        logic [2:0]  wb_word;
        logic        write_data;
        logic [2:0]  fill_word;
        logic [15:0] fill_data;
        logic        write_tag;
    } cache_ctl_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [2:0]             count;
    logic [2:0]             count_nxt;
    logic [LINE_BITS-1:0]   miss_line;
    logic [LINE_BITS-1:0]   evict_line;
    logic                   accept_miss;
    logic                   last_word;
    mem_req_t               mem_req;
    cache_ctl_t             cache_ctl;

    // Byte-offset bits of the request addresses carry no information for a line operation.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{miss_address[3:0], evict_address[3:0]};

    assign accept_miss = (state == IDLE) && miss_detected;
    assign last_word   = (count == LAST_WORD);

    // State and word counter register; reset wins over everything, including a pending miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= 3'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Snapshot both line addresses at acceptance so later input changes cannot disturb the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_line  <= '0;
            evict_line <= '0;
        end else if (accept_miss) begin
            miss_line  <= miss_address[ADDR_WIDTH-1:4];
            evict_line <= evict_address[ADDR_WIDTH-1:4];
        end
    end

    // Next-state and counter: counter is zero on entry to WB/FILL and wraps inside the line.
    always_comb begin
        state_nxt = state;
        count_nxt = 3'd0;
        case (state)
            IDLE: begin
                if (miss_detected) begin
                    state_nxt = evict_dirty ? WB : FILL;
                end
            end
            WB: begin
                if (last_word) begin
                    state_nxt = FILL;
                end else begin
                    count_nxt = count + 3'd1;
                end
            end
            FILL: begin
                // Wrap to 0 on the last word; there is no carry out of the 3-bit counter.
                count_nxt = count + 3'd1;
                if (last_word) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Moore outputs per state; every field not explicitly driven stays at zero.
    always_comb begin
        mem_req   = '0;
        cache_ctl = '0;
        case (state)
            WB: begin
                cache_ctl.busy    = 1'b1;
                cache_ctl.wb_word = count;
                mem_req.enable    = 1'b1;
                mem_req.wr        = 1'b1;
                mem_req.address   = {evict_line, count, 1'b0};
                mem_req.data      = evict_data;
            end
            FILL: begin
                cache_ctl.busy       = 1'b1;
                cache_ctl.write_data = 1'b1;
                cache_ctl.fill_word  = count;
                cache_ctl.fill_data  = mem_data_in;
                mem_req.enable       = 1'b1;
                mem_req.wr           = 1'b0;
                mem_req.address      = {miss_line, count, 1'b0};
            end
            DONE: begin
                cache_ctl.busy      = 1'b1;
                cache_ctl.write_tag = 1'b1;
            end
            default: begin
                cache_ctl = '0;
                mem_req   = '0;
            end
        endcase
    end

    assign fsm_busy         = cache_ctl.busy;
    assign wb_word          = cache_ctl.wb_word;
    assign write_data_array = cache_ctl.write_data;
    assign fill_word        = cache_ctl.fill_word;
    assign fill_data        = cache_ctl.fill_data;
    assign write_tag_array  = cache_ctl.write_tag;

    assign mem_enable   = mem_req.enable;
    // Gating with enable keeps a write strobe from ever appearing without a request.
    assign mem_wr       = mem_req.wr & mem_req.enable;
    assign mem_address  = mem_req.address;
    assign mem_data_out = mem_req.data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: clean, dirty, data, stability, reset and back-to-back cases.
// Outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Memory and victim line are modelled combinationally by the bench.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        evict_dirty;
    logic [15:0] evict_address;
    logic [15:0] evict_data;
    logic [15:0] mem_data_in;
    logic        fsm_busy;
    logic [2:0]  wb_word;
    logic        write_data_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic [15:0] mem_address;
    logic [15:0] mem_data_out;
    logic        mem_enable;
    logic        mem_wr;

    int checks = 0;
    int errors = 0;

    typedef logic [58:0] obs_t;

    logic [15:0] victim [0:7];
    obs_t        observed;

    always #5 clk = ~clk;

    cache_fill_fsm #(.ADDR_WIDTH(16), .LINE_WORDS(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .evict_dirty      (evict_dirty),
        .evict_address    (evict_address),
        .evict_data       (evict_data),
        .mem_data_in      (mem_data_in),
        .fsm_busy         (fsm_busy),
        .wb_word          (wb_word),
        .write_data_array (write_data_array),
        .fill_word        (fill_word),
        .fill_data        (fill_data),
        .write_tag_array  (write_tag_array),
        .mem_address      (mem_address),
        .mem_data_out     (mem_data_out),
        .mem_enable       (mem_enable),
        .mem_wr           (mem_wr)
    );

    // Memory contents: line 0x0200 holds 0x5A00+i, everything else a fixed scramble of the address.
    function automatic logic [15:0] mem_model(input logic [15:0] a);
        if (a[15:4] == 12'h020) return 16'h5A00 + {12'h0, 1'b0, a[3:1]};
        return a ^ 16'hC3A5;
    endfunction

    assign mem_data_in = mem_model(mem_address);
    assign evict_data  = victim[wb_word];

    function automatic obs_t pack(input logic busy, input logic en, input logic wr,
                                  input logic [15:0] addr, input logic [15:0] dout,
                                  input logic [2:0] wbw, input logic wda,
                                  input logic [2:0] fw, input logic [15:0] fd,
                                  input logic wta);
        return {busy, en, wr, addr, dout, wbw, wda, fw, fd, wta};
    endfunction

    assign observed = pack(fsm_busy, mem_enable, mem_wr, mem_address, mem_data_out,
                           wb_word, write_data_array, fill_word, fill_data, write_tag_array);

    function automatic obs_t e_idle();
        return pack(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
    endfunction

    function automatic obs_t e_done();
        return pack(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1);
    endfunction

    function automatic obs_t e_wb(input logic [15:0] line, input int i);
        logic [15:0] a;
        a = {line[15:4], 4'h0} + 16'(2 * i);
        return pack(1'b1, 1'b1, 1'b1, a, victim[i], 3'(i), 1'b0, 3'd0, 16'h0, 1'b0);
    endfunction

    function automatic obs_t e_fill(input logic [15:0] line, input int i);
        logic [15:0] a;
        a = {line[15:4], 4'h0} + 16'(2 * i);
        return pack(1'b1, 1'b1, 1'b0, a, 16'h0, 3'd0, 1'b1, 3'(i), mem_model(a), 1'b0);
    endfunction

    task automatic check(input string tag, input obs_t obs, input obs_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_fill(input string tag, input logic [15:0] line);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_fill%0d", tag, i), observed, e_fill(line, i));
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) victim[i] = 16'hE000 + 16'(16'h0111 * i);
        rst           = 1'b1;
        miss_detected = 1'b0;
        miss_address  = 16'h0;
        evict_dirty   = 1'b0;
        evict_address = 16'h0;

        // Reset state
        tick();
        tick();
        check("reset_idle", observed, e_idle());
        rst = 1'b0;
        tick();
        check("idle_no_miss", observed, e_idle());

        // Clean miss: reads 0x1230..0x123E, tag strobe in cycle 9, idle in cycle 10
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        evict_dirty   = 1'b0;
        evict_address = 16'h9990;
        tick();
        miss_detected = 1'b0;
        run_fill("clean", 16'h1230);
        check("clean_done", observed, e_done());
        tick();
        check("clean_idle", observed, e_idle());

        // Dirty miss: writes 0xABC0..0xABCE, reads 0x0040..0x004E, tag strobe in cycle 17
        miss_detected = 1'b1;
        miss_address  = 16'h0040;
        evict_address = 16'hABC0;
        evict_dirty   = 1'b1;
        tick();
        miss_detected = 1'b0;
        evict_dirty   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("dirty_wb%0d", i), observed, e_wb(16'hABC0, i));
            tick();
        end
        run_fill("dirty", 16'h0040);
        check("dirty_done", observed, e_done());
        tick();
        check("dirty_idle", observed, e_idle());

        // Data integrity on line 0x0200: fill_data 0x5A00+i with fill_word i
        miss_detected = 1'b1;
        miss_address  = 16'h0200;
        tick();
        miss_detected = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("data_pair%0d", i),
                  obs_t'({fill_word, fill_data}), obs_t'({3'(i), 16'h5A00 + 16'(i)}));
            tick();
        end
        check("data_done", observed, e_done());
        tick();

        // Input stability and address wrap at the top of the line (0x34F0..0x34FE)
        miss_detected = 1'b1;
        miss_address  = 16'h34FF;
        evict_dirty   = 1'b0;
        tick();
        miss_detected = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                miss_address  = 16'hFFF0;
                evict_address = 16'h1110;
                evict_dirty   = 1'b1;
            end
            if (i == 3) miss_detected = 1'b1;
            if (i == 4) miss_detected = 1'b0;
            check($sformatf("stab_fill%0d", i), observed, e_fill(16'h34F0, i));
            tick();
        end
        check("stab_done", observed, e_done());
        tick();
        check("stab_idle", observed, e_idle());
        tick();
        check("stab_idle2", observed, e_idle());
        evict_dirty = 1'b0;

        // Reset during the 3rd FILL cycle: outputs clear, no tag strobe follows
        miss_detected = 1'b1;
        miss_address  = 16'h7770;
        tick();
        miss_detected = 1'b0;
        check("abort_fill0", observed, e_fill(16'h7770, 0));
        tick();
        check("abort_fill1", observed, e_fill(16'h7770, 1));
        tick();
        check("abort_fill2", observed, e_fill(16'h7770, 2));
        rst = 1'b1;
        tick();
        check("rst_mid_fill", observed, e_idle());
        rst = 1'b0;
        tick();
        check("abort_no_tag1", observed, e_idle());
        tick();
        check("abort_no_tag2", observed, e_idle());

        // Reset during WB, then reset held together with miss_detected
        miss_detected = 1'b1;
        evict_dirty   = 1'b1;
        evict_address = 16'h4440;
        tick();
        check("abort_wb0", observed, e_wb(16'h4440, 0));
        tick();
        check("abort_wb1", observed, e_wb(16'h4440, 1));
        rst = 1'b1;
        tick();
        check("rst_mid_wb", observed, e_idle());
        tick();
        check("rst_priority", observed, e_idle());
        rst         = 1'b0;
        evict_dirty = 1'b0;
        miss_address = 16'h7770;
        tick();
        miss_detected = 1'b0;
        run_fill("restart", 16'h7770);
        check("restart_done", observed, e_done());
        tick();
        check("restart_idle", observed, e_idle());

        // Back-to-back: miss held high, second op starts after one idle cycle
        miss_detected = 1'b1;
        miss_address  = 16'h1110;
        tick();
        run_fill("b2b_a", 16'h1110);
        check("b2b_a_done", observed, e_done());
        miss_address = 16'h2220;
        tick();
        check("b2b_gap_idle", observed, e_idle());
        tick();
        miss_detected = 1'b0;
        run_fill("b2b_b", 16'h2220);
        check("b2b_b_done", observed, e_done());
        tick();
        check("b2b_b_idle", observed, e_idle());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
